load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 9 +
 rtl/lsu_align.sv | 30 +++
 rtl/load_store_unit.sv | 89 ++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 width encodings and FSM state type shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract/extend and store lane merge (combinational)
// ports: i_funct3 width code, i_lane addr[1:0], i_rdata memory word, i_wdata store data,
//        o_load_data extended load result, o_merge_data word to write back
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);
  logic [4:0]  w_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_b, w_is_h, w_sign;
  assign w_sh   = {i_lane, 3'b000};
  assign w_byte = 8'(i_rdata >> w_sh);
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_is_b = i_funct3[1:0] == F3_B[1:0];
  assign w_is_h = i_funct3[1:0] == F3_H[1:0];
  assign w_sign = i_funct3[2] == F3_B[2];
  assign o_load_data  = w_is_b ? {{24{w_sign & w_byte[7]}}, w_byte}
                      : w_is_h ? {{16{w_sign & w_half[15]}}, w_half}
                      : i_rdata;
  assign o_merge_data = w_is_b ? (i_rdata & ~(32'hFF << w_sh)) | ({24'b0, i_wdata[7:0]} << w_sh)
                      : w_is_h ? (i_lane[1] ? {i_wdata[15:0], i_rdata[15:0]} : {i_rdata[31:16], i_wdata[15:0]})
                      : i_wdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store unit with read-modify-write sub-word stores
// ports: clk/rst (sync, active-high); req_* core request (valid/ready handshake);
//        resp_* one-cycle completion pulse; mem_* word memory with registered read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_misaligned,
  output logic              resp_illegal,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [31:0]       mem_read_data
);
  lsu_state_t        r_state, w_next;
  logic              r_store, r_mis, r_ill;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_resp_data;
  logic              w_accept, w_ill, w_mis, w_sw;
  logic [31:0]       w_addr32, w_load_data, w_merge_data;
  assign w_accept = req_valid && r_state == IDLE;
  assign w_ill    = req_store ? req_funct3 > F3_W : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign w_mis    = (req_funct3[1:0] == F3_H[1:0] && req_addr[0])
                 || (req_funct3[1:0] == F3_W[1:0] && req_addr[1:0] != 2'b00);
  // full-word stores skip the read phase
  assign w_sw     = r_store && r_funct3 == F3_W;
  assign w_addr32 = 32'(r_addr);
  lsu_align u_align (
    .i_funct3    (r_funct3),
    .i_lane      (w_addr32[1:0]),
    .i_rdata     (mem_read_data),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_merge_data(w_merge_data)
  );
  always_comb begin
    w_next = r_state == IDLE  ? (w_accept ? ((w_ill || w_mis) ? RESP : ISSUE) : IDLE)
           : r_state == ISSUE ? (w_sw ? RESP : WAIT)
           : r_state == WAIT  ? RESP
           : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_store     <= 1'b0;
      r_funct3    <= 3'b0;
      r_addr      <= '0;
      r_wdata     <= 32'b0;
      r_resp_data <= 32'b0;
      r_mis       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store     <= req_store;
        r_funct3    <= req_funct3;
        r_addr      <= req_addr;
        r_wdata     <= req_wdata;
        r_resp_data <= 32'b0;
        r_ill       <= w_ill;
        r_mis       <= !w_ill && w_mis;
      end
      if (r_state == WAIT && !r_store) r_resp_data <= w_load_data;
    end
  end
  assign req_ready        = r_state == IDLE;
  assign resp_valid       = r_state == RESP;
  assign resp_data        = resp_valid ? r_resp_data : 32'b0;
  assign resp_misaligned  = resp_valid && r_mis;
  assign resp_illegal     = resp_valid && r_ill;
  assign mem_address      = (r_state == ISSUE || r_state == WAIT) ? {w_addr32[31:2], 2'b00} : 32'b0;
  // rst gates the strobes combinationally so a reset mid-RMW never commits a write
  assign mem_write_enable = !rst && ((r_state == ISSUE && w_sw) || (r_state == WAIT && r_store));
  assign mem_read_enable  = !rst && r_state == ISSUE && !w_sw;
  assign mem_write_data   = !mem_write_enable ? 32'b0 : r_state == ISSUE ? r_wdata : w_merge_data;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, corner sequences and random ops against a word-level reference model
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        resp_valid, resp_misaligned, resp_illegal;
  logic [31:0] resp_data, mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:63];
  int checks = 0, errors = 0, bad = 0, wen_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[9:2]] <= mem_write_data;
    if (mem_read_enable) mem_read_data <= mem[mem_address[9:2]];
  end

  always @(negedge clk) begin
    if ((mem_write_enable && mem_read_enable)
        || (req_ready && (mem_write_enable || mem_read_enable || mem_address != 32'b0))
        || ((mem_write_enable || mem_read_enable) && mem_address[1:0] != 2'b00)) bad <= bad + 1;
    if (mem_write_enable) wen_cnt <= wen_cnt + 1;
  end

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] a, wd, ed; logic em, ei;
    int lat, rc, wc; logic mc; logic [31:0] mv;
  } vec_t;
  vec_t tbl[20];
  vec_t bb[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] d, output logic m, output logic il, output int lat, output int rc, output int wc);
    @(negedge clk);
    set_req(st, f3, a, wd);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    set_req(1'($urandom), 3'($urandom), $urandom, $urandom);
    d = 32'b0; m = 1'b0; il = 1'b0; lat = 0; rc = 0; wc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read_enable && rc == 0) rc = c;
      if (mem_write_enable && wc == 0) wc = c;
      if (resp_valid) begin
        d = resp_data; m = resp_misaligned; il = resp_illegal; lat = c;
        break;
      end
    end
    @(negedge clk);
    chk("pulse_end", 32'(resp_valid), 32'd0);
    chk("data_idle", resp_data, 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] ed, output logic em, output logic ei, output int lat);
    int w, fi, lo, nb, sh;
    logic [31:0] word, mask, v;
    w = int'((a - 32'h100) >> 2);
    fi = int'(f3);
    lo = int'(a[1:0]);
    sh = lo * 8;
    word = ref_mem[w];
    ei = st ? (fi > 2) : (fi == 3 || fi >= 6);
    em = !ei && (((fi % 4) == 1 && lo % 2 == 1) || (fi == 2 && lo != 0));
    ed = 32'b0;
    lat = 3;
    if (ei || em) lat = 1;
    else if (st) begin
      if (fi == 2) lat = 2;
      nb = (fi == 0) ? 1 : (fi == 1) ? 2 : 4;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1) << sh;
      ref_mem[w] = (word & ~mask) | ((wd << sh) & mask);
    end else begin
      nb = ((fi % 4) == 0) ? 1 : ((fi % 4) == 1) ? 2 : 4;
      v = word >> sh;
      if (nb < 4) begin
        v = v & ((32'd1 << (8 * nb)) - 32'd1);
        if (fi < 4 && v[8 * nb - 1]) v = v - (32'd1 << (8 * nb));
      end
      ed = v;
    end
  endtask

  initial begin
    logic [31:0] d, ed;
    logic m, il, em, ei, rdy;
    int lat, rc, wc, elat, acc, k, w0;
    logic [33:0] got[$];

    tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 2, 0, 1, 1'b1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0,        1'b0, 1'b0, 2, 0, 1, 1'b1, 32'h80FF7F01};
    tbl[3]  = '{1'b0, 3'b000, 32'h21, 32'h0,        32'h0000007F, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 3'b100, 32'h22, 32'h0,        32'h000000FF, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF80FF, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 3'b101, 32'h22, 32'h0,        32'h000080FF, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 3'b010, 32'h30, 32'h11223344, 32'h0,        1'b0, 1'b0, 2, 0, 1, 1'b1, 32'h11223344};
    tbl[9]  = '{1'b1, 3'b000, 32'h31, 32'hFFFFFFAA, 32'h0,        1'b0, 1'b0, 3, 1, 2, 1'b1, 32'h1122AA44};
    tbl[10] = '{1'b1, 3'b001, 32'h32, 32'h1234BEEF, 32'h0,        1'b0, 1'b0, 3, 1, 2, 1'b1, 32'hBEEFAA44};
    tbl[11] = '{1'b0, 3'b010, 32'h30, 32'h0,        32'hBEEFAA44, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0, 1'b0, 32'h0};
    tbl[13] = '{1'b1, 3'b011, 32'h10, 32'h55555555, 32'h0,        1'b0, 1'b1, 1, 0, 0, 1'b1, 32'hDEADBEEF};
    tbl[14] = '{1'b0, 3'b001, 32'h21, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 0, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 3'b110, 32'h21, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 3'b101, 32'h22, 32'h0000CAFE, 32'h0,        1'b0, 1'b1, 1, 0, 0, 1'b1, 32'h80FF7F01};
    tbl[17] = '{1'b0, 3'b111, 32'h07, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 3'b001, 32'h20, 32'h0,        32'h00007F01, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 3'b100, 32'h23, 32'h0,        32'h00000080, 1'b0, 1'b0, 3, 1, 0, 1'b0, 32'h0};

    bb[0] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0};
    bb[1] = '{1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0,        1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0};
    bb[2] = '{1'b0, 3'b010, 32'h40, 32'h0,        32'h12345678, 1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0};
    bb[3] = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        1'b1, 1'b0, 0, 0, 0, 1'b0, 32'h0};
    bb[4] = '{1'b0, 3'b100, 32'h23, 32'h0,        32'h00000080, 1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_wen", 32'(mem_write_enable), 32'd0);
    chk("rst_ren", 32'(mem_read_enable), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_flags", 32'({resp_illegal, resp_misaligned}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("addr_idle", mem_address, 32'd0);

    for (int i = 0; i < 20; i++) begin
      do_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, d, m, il, lat, rc, wc);
      chk($sformatf("v%0d_data", i), d, tbl[i].ed);
      chk($sformatf("v%0d_mis", i), 32'(m), 32'(tbl[i].em));
      chk($sformatf("v%0d_ill", i), 32'(il), 32'(tbl[i].ei));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d_rd_cyc", i), 32'(rc), 32'(tbl[i].rc));
      chk($sformatf("v%0d_wr_cyc", i), 32'(wc), 32'(tbl[i].wc));
      if (tbl[i].mc) chk($sformatf("v%0d_mem", i), mem[tbl[i].a[9:2]], tbl[i].mv);
    end

    // reset asserted during the WAIT cycle of an SB read-modify-write
    w0 = wen_cnt;
    @(negedge clk);
    set_req(1'b1, 3'b000, 32'h31, 32'h00000055);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_issue_ren", 32'(mem_read_enable), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rmw_rst_wen", 32'(mem_write_enable), 32'd0);
    chk("rmw_rst_ren", 32'(mem_read_enable), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmw_ready", 32'(req_ready), 32'd1);
    chk("rmw_no_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("rmw_no_wen", 32'(wen_cnt), 32'(w0));
    chk("rmw_mem", mem[12], 32'hBEEFAA44);

    // req_valid held high across back-to-back requests
    acc = 0; k = 0;
    @(negedge clk);
    set_req(bb[0].st, bb[0].f3, bb[0].a, bb[0].wd);
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (resp_valid) got.push_back({resp_illegal, resp_misaligned, resp_data});
      rdy = req_ready && req_valid;
      @(posedge clk);
      if (rdy) begin
        acc++; k++;
        #1;
        if (k < 5) set_req(bb[k].st, bb[k].f3, bb[k].a, bb[k].wd);
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd5);
    chk("b2b_resps", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++) begin
      chk($sformatf("b2b%0d_data", i), got[i][31:0], bb[i].ed);
      chk($sformatf("b2b%0d_flags", i), 32'(got[i][33:32]), 32'({bb[i].ei, bb[i].em}));
    end
    chk("b2b_mem", mem[16], 32'h12345678);

    // random ops in bytes 0x100..0x1FF against the reference model
    for (int w = 0; w < 64; w++) begin
      ref_mem[w] = $urandom;
      do_req(1'b1, 3'b010, 32'h100 + 32'(w * 4), ref_mem[w], d, m, il, lat, rc, wc);
    end
    for (int n = 0; n < 150; n++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] a, wd;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 32'h100 + 32'($urandom_range(0, 255));
      wd = $urandom;
      model(st, f3, a, wd, ed, em, ei, elat);
      do_req(st, f3, a, wd, d, m, il, lat, rc, wc);
      chk($sformatf("r%0d_data", n), d, ed);
      chk($sformatf("r%0d_mis", n), 32'(m), 32'(em));
      chk($sformatf("r%0d_ill", n), 32'(il), 32'(ei));
      chk($sformatf("r%0d_lat", n), 32'(lat), 32'(elat));
    end
    for (int w = 0; w < 64; w++) chk($sformatf("rmem%0d", w), mem[64 + w], ref_mem[w]);
    chk("bus_protocol", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
